// File: rtl/mem_access_stage.sv
// MEM stage of the RV64 pipeline. Issues loads/stores to data memory over a
// req/ack handshake, lane-aligns store data, extends load data, stalls the
// front of the pipe while an access is outstanding and feeds MEM_WB.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [63:0] alu_result_in,
    input  logic [63:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [63:0] read_data,
    output logic [63:0] result,
    output logic [4:0]  rd,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [7:0]  wait_q;
    logic        fault_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        mem_to_reg_q;
    logic        reg_write_q;
    logic [63:0] rdata_q;

    logic        memop;
    logic        illegal;
    logic        unaligned;
    logic        fault;
    logic [63:0] wdata_d;
    logic [7:0]  wstrb_d;
    logic [63:0] load_shifted;
    logic [63:0] load_ext;
    logic        timeout;

    assign memop   = valid_in & (mem_read_in | mem_write_in);
    assign timeout = (wait_q == 8'(MAX_WAIT)) & ~dmem_ack;

    // Classify the incoming access: illegal size or address not naturally aligned.
    always_comb begin
        illegal   = mem_write_in ? funct3_in[2] : (funct3_in == 3'b111);
        unaligned = 1'b0;
        case (funct3_in[1:0])
            2'd1:    unaligned = alu_result_in[0];
            2'd2:    unaligned = |alu_result_in[1:0];
            2'd3:    unaligned = |alu_result_in[2:0];
            default: unaligned = 1'b0;
        endcase
        fault = illegal | unaligned;
    end

    // Place store data and byte enables into the addressed lanes; loads use no strobes.
    always_comb begin
        wdata_d = store_data_in << {alu_result_in[2:0], 3'b000};
        wstrb_d = 8'h00;
        if (mem_write_in) begin
            case (funct3_in[1:0])
                2'd0:    wstrb_d = 8'h01 << alu_result_in[2:0];
                2'd1:    wstrb_d = 8'h03 << alu_result_in[2:0];
                2'd2:    wstrb_d = 8'h0F << alu_result_in[2:0];
                default: wstrb_d = 8'hFF;
            endcase
        end
    end

    // Pull the addressed element out of the returned doubleword and extend it.
    always_comb begin
        load_shifted = dmem_rdata >> {addr_q[2:0], 3'b000};
        case (funct3_q[1:0])
            2'd0:    load_ext = {{56{~funct3_q[2] & load_shifted[7]}}, load_shifted[7:0]};
            2'd1:    load_ext = {{48{~funct3_q[2] & load_shifted[15]}}, load_shifted[15:0]};
            2'd2:    load_ext = {{32{~funct3_q[2] & load_shifted[31]}}, load_shifted[31:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // Access FSM: latch the op in IDLE, wait for ack (or time out) in BUSY, write back in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            wait_q       <= 8'd0;
            fault_q      <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            wstrb_q      <= 8'd0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            rd_q         <= 5'd0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            rdata_q      <= 64'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (memop && !fault) begin
                        addr_q       <= alu_result_in;
                        wdata_q      <= wdata_d;
                        wstrb_q      <= wstrb_d;
                        we_q         <= mem_write_in;
                        funct3_q     <= funct3_in;
                        rd_q         <= rd_in;
                        mem_to_reg_q <= mem_to_reg_in;
                        reg_write_q  <= reg_write_in;
                        fault_q      <= 1'b0;
                        wait_q       <= 8'd0;
                        state_q      <= StBusy;
                    end
                end
                StBusy: begin
                    if (dmem_ack) begin
                        rdata_q <= load_ext;
                        state_q <= StDone;
                    end else if (timeout) begin
                        fault_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dmem_req   = (state_q == StBusy);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[63:3], 3'b000};
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign misaligned = (state_q == StIdle) & memop & fault;
    assign bus_error  = (state_q == StBusy) & timeout;

    // MEM_WB-facing outputs: pass-through when idle, latched op while busy/done.
    always_comb begin
        stall          = 1'b0;
        reg_write_out  = 1'b0;
        result         = alu_result_in;
        rd             = rd_in;
        mem_to_reg_out = mem_to_reg_in;
        read_data      = rdata_q;
        unique case (state_q)
            StIdle: begin
                stall         = memop & ~fault;
                reg_write_out = valid_in & reg_write_in & ~memop;
            end
            StBusy: begin
                stall          = 1'b1;
                result         = addr_q;
                rd             = rd_q;
                mem_to_reg_out = mem_to_reg_q;
            end
            StDone: begin
                result         = addr_q;
                rd             = rd_q;
                mem_to_reg_out = mem_to_reg_q;
                reg_write_out  = reg_write_q & ~fault_q;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short MAX_WAIT to reach the timeout.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [63:0] alu_result_in;
    logic [63:0] store_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        mem_to_reg_in;
    logic        reg_write_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic [63:0] read_data;
    logic [63:0] result;
    logic [4:0]  rd;
    logic        mem_to_reg_out;
    logic        reg_write_out;
    logic        misaligned;
    logic        bus_error;

    int n_cmp = 0;
    int n_bad = 0;

    // Snapshot of the request as seen on the first BUSY cycle.
    logic [63:0] snap_addr;
    logic [63:0] snap_wdata;
    logic [7:0]  snap_wstrb;
    logic        snap_we;

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_in       (valid_in),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .rd_in          (rd_in),
        .funct3_in      (funct3_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .reg_write_in   (reg_write_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .stall          (stall),
        .read_data      (read_data),
        .result         (result),
        .rd             (rd),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_write_out  (reg_write_out),
        .misaligned     (misaligned),
        .bus_error      (bus_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in      = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        reg_write_in  = 1'b0;
    endtask

    // Present a memory op in IDLE, stay `waits` extra BUSY cycles, ack, and stop in DONE.
    task automatic mem_op(input logic [2:0] f3, input logic wr, input logic [63:0] addr,
                          input logic [63:0] sdata, input logic [63:0] rdata, input int waits);
        valid_in      = 1'b1;
        mem_read_in   = ~wr;
        mem_write_in  = wr;
        mem_to_reg_in = ~wr;
        reg_write_in  = ~wr;
        funct3_in     = f3;
        alu_result_in = addr;
        store_data_in = sdata;
        rd_in         = 5'd9;
        #1;
        check("idle_stall", {63'd0, stall}, 64'd1);
        check("idle_no_wb", {63'd0, reg_write_out}, 64'd0);
        tick();
        snap_addr  = dmem_addr;
        snap_wdata = dmem_wdata;
        snap_wstrb = dmem_wstrb;
        snap_we    = dmem_we;
        for (int i = 0; i < waits; i++) begin
            check("busy_req", {63'd0, dmem_req}, 64'd1);
            tick();
        end
        check("busy_req_ack", {63'd0, dmem_req}, 64'd1);
        dmem_rdata = rdata;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        idle_inputs();
        #1;
    endtask

    initial begin
        int req_cycles;
        int berr_cycles;
        reset         = 1'b1;
        idle_inputs();
        alu_result_in = 64'd0;
        store_data_in = 64'd0;
        rd_in         = 5'd0;
        funct3_in     = 3'd0;
        dmem_rdata    = 64'd0;
        dmem_ack      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_req", {63'd0, dmem_req}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_wb", {63'd0, reg_write_out}, 64'd0);
        check("rst_rdata", read_data, 64'd0);

        // ADD pass-through
        valid_in      = 1'b1;
        reg_write_in  = 1'b1;
        alu_result_in = 64'h1234;
        rd_in         = 5'd5;
        #1;
        check("add_stall", {63'd0, stall}, 64'd0);
        check("add_result", result, 64'h1234);
        check("add_wb", {63'd0, reg_write_out}, 64'd1);
        check("add_rd", {59'd0, rd}, 64'd5);
        tick();
        idle_inputs();

        // LB at 0x1003
        mem_op(3'b000, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0);
        check("lb_addr", snap_addr, 64'h1000);
        check("lb_we", {63'd0, snap_we}, 64'd0);
        check("lb_strb", {56'd0, snap_wstrb}, 64'd0);
        check("lb_done_req", {63'd0, dmem_req}, 64'd0);
        check("lb_done_stall", {63'd0, stall}, 64'd0);
        check("lb_data", read_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_wb", {63'd0, reg_write_out}, 64'd1);
        check("lb_result", result, 64'h1003);
        check("lb_rd", {59'd0, rd}, 64'd9);
        tick();

        // LBU same address
        mem_op(3'b100, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0);
        check("lbu_data", read_data, 64'h80);
        tick();

        // LW at 0x3004 with two extra wait cycles, sign-extended upper word
        mem_op(3'b010, 1'b0, 64'h3004, 64'd0, 64'h89AB_CDEF_0000_0000, 2);
        check("lw_data", read_data, 64'hFFFF_FFFF_89AB_CDEF);
        check("lw_addr", snap_addr, 64'h3000);
        tick();

        // SH at 0x2006
        mem_op(3'b001, 1'b1, 64'h2006, 64'hBEEF, 64'd0, 0);
        check("sh_strb", {56'd0, snap_wstrb}, 64'hC0);
        check("sh_wdata", snap_wdata, 64'hBEEF_0000_0000_0000);
        check("sh_we", {63'd0, snap_we}, 64'd1);
        check("sh_addr", snap_addr, 64'h2000);
        check("sh_done_wb", {63'd0, reg_write_out}, 64'd0);
        tick();

        // SD at 0x5008: full strobes
        mem_op(3'b011, 1'b1, 64'h5008, 64'h0102_0304_0506_0708, 64'd0, 0);
        check("sd_strb", {56'd0, snap_wstrb}, 64'hFF);
        check("sd_wdata", snap_wdata, 64'h0102_0304_0506_0708);
        tick();

        // Misaligned LW at 0x3002
        valid_in      = 1'b1;
        mem_read_in   = 1'b1;
        reg_write_in  = 1'b1;
        funct3_in     = 3'b010;
        alu_result_in = 64'h3002;
        #1;
        check("mis_pulse", {63'd0, misaligned}, 64'd1);
        check("mis_stall", {63'd0, stall}, 64'd0);
        check("mis_wb", {63'd0, reg_write_out}, 64'd0);
        tick();
        idle_inputs();
        #1;
        check("mis_req", {63'd0, dmem_req}, 64'd0);
        check("mis_clear", {63'd0, misaligned}, 64'd0);

        // Illegal store size (SBU-like funct3=100)
        valid_in     = 1'b1;
        mem_write_in = 1'b1;
        funct3_in    = 3'b100;
        alu_result_in = 64'h6000;
        #1;
        check("ill_pulse", {63'd0, misaligned}, 64'd1);
        tick();
        idle_inputs();
        #1;
        check("ill_req", {63'd0, dmem_req}, 64'd0);

        // LD timeout with MAX_WAIT=4: request held 5 cycles, one bus_error pulse
        valid_in      = 1'b1;
        mem_read_in   = 1'b1;
        reg_write_in  = 1'b1;
        mem_to_reg_in = 1'b1;
        funct3_in     = 3'b011;
        alu_result_in = 64'h4000;
        tick();
        req_cycles  = 0;
        berr_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            if (bus_error) berr_cycles++;
            tick();
        end
        idle_inputs();
        #1;
        check("to_req_cycles", 64'(req_cycles), 64'd5);
        check("to_berr_pulses", 64'(berr_cycles), 64'd1);
        check("to_done_wb", {63'd0, reg_write_out}, 64'd0);
        check("to_done_stall", {63'd0, stall}, 64'd0);
        tick();

        // LD interrupted by reset in BUSY; later ack must be ignored
        valid_in      = 1'b1;
        mem_read_in   = 1'b1;
        reg_write_in  = 1'b1;
        funct3_in     = 3'b011;
        alu_result_in = 64'h7000;
        tick();
        check("rstbusy_req", {63'd0, dmem_req}, 64'd1);
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rstbusy_req_drop", {63'd0, dmem_req}, 64'd0);
        check("rstbusy_stall", {63'd0, stall}, 64'd0);
        dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        #1;
        check("rstbusy_wb", {63'd0, reg_write_out}, 64'd0);
        check("rstbusy_data", read_data, 64'd0);
        check("rstbusy_req2", {63'd0, dmem_req}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
